// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end blocks: window generator state
// encoding and the mapping from window coordinates to shift-register taps.
package cnn_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } gen_state_t;

    // Tap holding window element (r,c); tap 0 is the newest pixel, and the
    // top-left element is the oldest one still inside the window.
    function automatic int tap_index(input int r, input int c,
                                     input int kernel_size, input int column_size);
        return (kernel_size - 1 - r) * column_size + (kernel_size - 1 - c);
    endfunction

endpackage

// File: rtl/window_shift_buffer.sv
// Line-buffer style shift register for the window generator. It exposes the
// contents as they will be after this cycle's shift, so the caller can
// register a window that already includes the pixel entering at tap 0.
module window_shift_buffer #(
    parameter int DEPTH      = 59,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          shift_en,
    input  logic [DATA_WIDTH-1:0]         shift_data,
    output logic [DEPTH*DATA_WIDTH-1:0]   taps_next
);

    logic [DEPTH*DATA_WIDTH-1:0] taps;

    // Contents after this cycle: shifted by one word when enabled, else held.
    always_comb begin
        taps_next = taps;
        if (shift_en) begin
            taps_next = {taps[(DEPTH-1)*DATA_WIDTH-1:0], shift_data};
        end
    end

    // Storage deliberately has no reset; every tap is rewritten before use.
    always_ff @(posedge clock) begin
        taps <= taps_next;
    end

endmodule

// File: rtl/window_generator.sv
// Sliding KERNEL_SIZE x KERNEL_SIZE window generator over a raster pixel
// stream. A FILL/STREAM/FLUSH controller decides when windows are emitted
// and pads each frame with flush windows so the per-frame window count is a
// whole number of rows.
module window_generator
    import cnn_pkg::*;
#(
    parameter int COLUMN_SIZE = 28,
    parameter int ROW_SIZE    = 28,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                                          clock,
    input  logic                                          sreset,
    input  logic [DATA_WIDTH-1:0]                         pixel_in,
    input  logic                                          pixel_valid,
    output logic                                          in_ready,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window,
    output logic                                          window_valid,
    output logic                                          frame_done
);

    localparam int DEPTH = (KERNEL_SIZE - 1) * COLUMN_SIZE + KERNEL_SIZE;
    localparam int WIN_W = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW    = $clog2(COLUMN_SIZE);
    localparam int RW    = $clog2(ROW_SIZE);
    localparam int FW    = $clog2(KERNEL_SIZE);

    localparam logic [CW-1:0] COL_LAST   = CW'(COLUMN_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROW_SIZE - 1);
    localparam logic [CW-1:0] FILL_COL   = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] FILL_ROW   = RW'(KERNEL_SIZE - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(KERNEL_SIZE - 2);

    gen_state_t              state;
    gen_state_t              state_next;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [FW-1:0]           flush_cnt;

    logic                    accept;
    logic                    at_fill_end;
    logic                    at_frame_end;
    logic                    flush_last;
    logic                    shift_en;
    logic [DATA_WIDTH-1:0]   shift_data;
    logic                    emit;
    logic                    done_next;
    logic [DEPTH*DATA_WIDTH-1:0] taps_next;
    logic [WIN_W-1:0]        window_next;

    assign accept       = pixel_valid & in_ready;
    assign at_fill_end  = (row == FILL_ROW) && (col == FILL_COL);
    assign at_frame_end = (row == ROW_LAST) && (col == COL_LAST);
    assign flush_last   = (flush_cnt == FLUSH_LAST);

    window_shift_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clock      (clock),
        .shift_en   (shift_en),
        .shift_data (shift_data),
        .taps_next  (taps_next)
    );

    // Controller state register.
    always_ff @(posedge clock) begin
        if (sreset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a frame no larger than the kernel ends while filling.
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept && at_fill_end) begin
                    state_next = at_frame_end ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (accept && at_frame_end) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_last) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Per-state outputs: readiness, what enters the buffer, and whether a window is emitted.
    always_comb begin
        in_ready   = 1'b1;
        shift_en   = 1'b0;
        shift_data = pixel_in;
        emit       = 1'b0;
        done_next  = 1'b0;
        case (state)
            FILL: begin
                shift_en = accept;
                emit     = accept && at_fill_end;
            end
            STREAM: begin
                shift_en = accept;
                emit     = accept;
            end
            FLUSH: begin
                in_ready   = 1'b0;
                shift_en   = 1'b1;
                shift_data = '0;
                emit       = 1'b1;
                done_next  = flush_last;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
        if (sreset) begin
            shift_en = 1'b0;
        end
    end

    // Raster position of the next pixel; wraps to the frame origin after the last pixel.
    always_ff @(posedge clock) begin
        if (sreset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Counts flush cycles while in FLUSH; idles at zero otherwise.
    always_ff @(posedge clock) begin
        if (sreset || (state != FLUSH)) begin
            flush_cnt <= '0;
        end else begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Gather the window elements from their taps, row 0 being the oldest.
    always_comb begin
        window_next = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                window_next[DATA_WIDTH*(r*KERNEL_SIZE+c) +: DATA_WIDTH] =
                    taps_next[DATA_WIDTH*tap_index(r, c, KERNEL_SIZE, COLUMN_SIZE) +: DATA_WIDTH];
            end
        end
    end

    // Output register: window updates only when emitted and holds otherwise.
    always_ff @(posedge clock) begin
        if (sreset) begin
            window       <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= emit;
            frame_done   <= done_next;
            if (emit) begin
                window <= window_next;
            end
        end
    end

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench for window_generator on a 5x5 frame with a 3x3 kernel.
// Directed steps push expected windows to a scoreboard; a negedge monitor pops
// and compares them whenever window_valid is seen.
module tb_window_generator;

    localparam int COLS = 5;
    localparam int ROWS = 5;
    localparam int K    = 3;
    localparam int DW   = 16;
    localparam int WW   = DW * K * K;
    localparam int FIRST_WIN_PX   = (K - 1) * COLS + (K - 1);
    localparam int WINS_PER_FRAME = (ROWS - K + 1) * COLS;

    typedef struct {
        logic [WW-1:0] win;
        bit            check_win;
        bit            done;
    } exp_t;

    logic          clock = 1'b0;
    logic          sreset;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid;
    logic          in_ready;
    logic [WW-1:0] window;
    logic          window_valid;
    logic          frame_done;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   valid_count = 0;
    int   mod_count   = 0;
    logic [WW-1:0] last_win = '0;

    window_generator #(
        .COLUMN_SIZE (COLS),
        .ROW_SIZE    (ROWS),
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW)
    ) dut (
        .clock        (clock),
        .sreset       (sreset),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .in_ready     (in_ready),
        .window       (window),
        .window_valid (window_valid),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    // Window expected after accepting raster pixel p, whose value equals its index.
    function automatic logic [WW-1:0] exp_window(input int p);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[DW*(r*K+c) +: DW] = DW'(p - ((K - 1 - r) * COLS + (K - 1 - c)));
            end
        end
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [WW-1:0] observed,
                                input logic [WW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Monitor: scoreboard compare on every valid, hold and frame_done checks otherwise.
    always @(negedge clock) begin
        if (window_valid === 1'b1) begin
            valid_count++;
            mod_count = (mod_count + 1) % COLS;
            if (sb_q.size() == 0) begin
                check_value("unexpected_window_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.check_win) begin
                    check_output("window_data", window, e.win);
                end
                check_value("frame_done_with_valid", 32'(frame_done), 32'(e.done));
            end
            if (frame_done === 1'b1) begin
                check_value("row_counter_wrap_at_frame_done", 32'(mod_count), 32'd0);
            end
            last_win = window;
        end else begin
            check_output("window_hold", window, last_win);
            check_value("frame_done_without_valid", 32'(frame_done), 32'd0);
        end
        if (sreset === 1'b1) begin
            last_win    = '0;
            valid_count = 0;
            mod_count   = 0;
        end
    end

    // Drive raster pixels first_px..last_px, optionally with random idle gaps.
    task automatic apply_stimulus(input int first_px, input int last_px, input bit gaps);
        for (int p = first_px; p <= last_px; p++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    pixel_valid = 1'b0;
                    pixel_in    = 16'hdead;
                    @(posedge clock);
                    #1;
                    check_value("gap_no_valid", 32'(window_valid), 32'd0);
                end
            end
            check_value("in_ready_accepting", 32'(in_ready), 32'd1);
            pixel_valid = 1'b1;
            pixel_in    = DW'(p);
            if (p >= FIRST_WIN_PX) begin
                sb_q.push_back('{exp_window(p), 1'b1, 1'b0});
            end
            @(posedge clock);
            #1;
            check_value("valid_latency", 32'(window_valid), (p >= FIRST_WIN_PX) ? 32'd1 : 32'd0);
        end
        pixel_valid = 1'b0;
    endtask

    // Flush phase after the last pixel, then drain the scoreboard and check the count.
    task automatic finish_frame(input bit drop);
        check_value("flush_in_ready_cycle1", 32'(in_ready), 32'd0);
        sb_q.push_back('{'0, 1'b0, 1'b0});
        sb_q.push_back('{'0, 1'b0, 1'b1});
        if (drop) begin
            pixel_valid = 1'b1;
            pixel_in    = 16'd99;
        end
        @(posedge clock);
        #1;
        check_value("flush_in_ready_cycle2", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        pixel_valid = 1'b0;
        check_value("in_ready_after_flush", 32'(in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clock);
            #1;
        end
        check_value("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check_value("windows_per_frame", 32'(valid_count), 32'(WINS_PER_FRAME));
        valid_count = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sreset      = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 16'd77;
        repeat (3) @(posedge clock);
        #1;
        check_value("reset_window_valid", 32'(window_valid), 32'd0);
        check_value("reset_frame_done", 32'(frame_done), 32'd0);
        check_output("reset_window", window, '0);
        pixel_valid = 1'b0;
        sreset      = 1'b0;
        check_value("in_ready_after_reset", 32'(in_ready), 32'd1);

        $display("[TB] frame 1: back-to-back pixels");
        apply_stimulus(0, ROWS*COLS-1, 1'b0);
        finish_frame(1'b0);

        $display("[TB] frame 2: random gaps");
        apply_stimulus(0, ROWS*COLS-1, 1'b1);
        finish_frame(1'b0);

        $display("[TB] frames 3-4: pixel offered during flush");
        apply_stimulus(0, ROWS*COLS-1, 1'b0);
        finish_frame(1'b1);
        apply_stimulus(0, ROWS*COLS-1, 1'b0);
        finish_frame(1'b0);

        $display("[TB] reset mid-stream");
        apply_stimulus(0, 17, 1'b0);
        sreset      = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 16'd55;
        @(posedge clock);
        #1;
        check_value("midreset_window_valid", 32'(window_valid), 32'd0);
        check_value("midreset_frame_done", 32'(frame_done), 32'd0);
        check_output("midreset_window", window, '0);
        check_value("midreset_scoreboard_empty", 32'(sb_q.size()), 32'd0);
        sreset      = 1'b0;
        pixel_valid = 1'b0;
        check_value("in_ready_after_midreset", 32'(in_ready), 32'd1);
        apply_stimulus(0, ROWS*COLS-1, 1'b0);
        finish_frame(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter COLUMN_SIZE, default 28, gives the pixels per image row.
REQ-002 Parameter ROW_SIZE, default 28, gives the rows per frame.
REQ-003 Parameter KERNEL_SIZE, default 3, gives the window edge; legal range is 2 to ROW_SIZE and 2 to COLUMN_SIZE.
REQ-004 Parameter DATA_WIDTH, default 16, gives the pixel width in bits, fixed-point and opaque to this block.
REQ-005 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-006 Ports, in order:
- clock  in  1  rising-edge clock.
- sreset  in  1  synchronous active-high reset.
- pixel_in  in  DATA_WIDTH  raster-order pixel.
- pixel_valid  in  1  pixel_in is valid this cycle.
- in_ready  out  1  block accepts a pixel this cycle.
- window  out  DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE  packed window.
- window_valid  out  1  window is valid.
- frame_done  out  1  one-cycle pulse marking the end of a frame.
REQ-007 Window element l = r*KERNEL_SIZE + c SHALL occupy bits [DATA_WIDTH*(l+1)-1 : DATA_WIDTH*l].
- r = 0 is the top (oldest) row.
- c = 0 is the leftmost column.

Function
REQ-008 A pixel is accepted when pixel_valid and in_ready are both 1; only accepted pixels advance the buffer or the counters.
REQ-009 Buffer: a shift register of depth (KERNEL_SIZE-1)*COLUMN_SIZE + KERNEL_SIZE; each accepted pixel enters at tap 0.
REQ-010 Tap mapping: window element (r,c) SHALL equal tap (KERNEL_SIZE-1-r)*COLUMN_SIZE + (KERNEL_SIZE-1-c).
REQ-011 Counters: col counts 0..COLUMN_SIZE-1 and row counts 0..ROW_SIZE-1, both advanced per accepted pixel; col wraps to 0 and increments row.
REQ-012 State machine, three states:
- FILL: reset state.
- STREAM.
- FLUSH.
REQ-013 FILL: in_ready=1 and no window_valid is produced; the block moves to STREAM on accepting the pixel at (row KERNEL_SIZE-1, col KERNEL_SIZE-1).
REQ-014 STREAM: in_ready=1 and every accepted pixel, including the transition pixel from FILL, produces exactly one window_valid pulse.
REQ-015 Output latency SHALL be 1 cycle: window and window_valid are registered and appear on the cycle after acceptance.
REQ-016 End of frame: accepting the pixel at (ROW_SIZE-1, COLUMN_SIZE-1) in STREAM moves the block to FLUSH.
REQ-017 FLUSH lasts KERNEL_SIZE-1 cycles. In each cycle:
- in_ready=0.
- a zero is shifted into tap 0.
- window_valid=1 on the following cycle.
REQ-018 The flush windows are don't-care data. They make the per-frame window_valid count exactly (ROW_SIZE-KERNEL_SIZE+1)*COLUMN_SIZE, so a downstream per-row column counter wraps to 0 at frame end.
REQ-019 frame_done SHALL be 1 in the same cycle as the last flush window_valid and 0 otherwise.
REQ-020 After FLUSH the block SHALL return to FILL with row=0 and col=0; buffer contents are not cleared.
REQ-021 pixel_valid while in_ready=0 SHALL be ignored: no shift, no count, no output.
REQ-022 Gaps: with pixel_valid=0 in FILL or STREAM, state, counters and buffer SHALL hold and window_valid=0 the next cycle.
REQ-023 window SHALL hold its last value whenever window_valid=0.
REQ-024 Columns whose window wraps across a row boundary SHALL still be emitted; masking them is the downstream consumer's job.

Reset
REQ-025 sreset=1 at a rising edge SHALL force all of the following, overriding pixel_valid and any state, including mid-frame and mid-FLUSH:
- state=FILL.
- row=0, col=0.
- window_valid=0, frame_done=0.
- window=0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 Buffer storage SHALL be non-reset; correctness follows from FILL rewriting every tap before the first valid.

Structure
REQ-028 State encodings (FILL=0, STREAM=1, FLUSH=2) and the tap-index function SHALL live in the shared package cnn_pkg.
REQ-029 One sub-module SHALL be used: window_shift_buffer, holding the parameterised shift register with its tap outputs.
REQ-030 The control FSM and counters SHALL reside in window_generator.

Verification
All scenarios use COLUMN_SIZE=5, ROW_SIZE=5, KERNEL_SIZE=3, DATA_WIDTH=16, and pixel value = raster index 0..24.
REQ-031 Back-to-back frame: the first window_valid follows acceptance of pixel 12 by one cycle, with window = {0,1,2,5,6,7,10,11,12} in elements 0..8.
REQ-032 Count check: the frame produces 15 window_valid pulses. After pixel 24, in_ready=0 for 2 cycles, and frame_done pulses with the 15th valid.
REQ-033 Gaps: insert random pixel_valid=0 cycles. Windows and count are identical to REQ-031/032, and there is no window_valid during gaps.
REQ-034 Drop during flush: assert pixel_valid=1 with value 99 during FLUSH. It is ignored, and the next frame's first window contains no 99.
REQ-035 Reset mid-stream: assert sreset after pixel 17. Outputs go to zero, and a fresh frame yields the REQ-031 window on its 13th accepted pixel.
REQ-036 Two consecutive frames: a downstream modulo-5 counter of window_valid reads 0 at each frame_done.
